uart_tx_cfg: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter: serialises words of configurable width with optional odd/even parity and 1 or 2 stop bits. Ready/valid write port with a one-entry holding register, so back-to-back frames go out with no idle gap. Sits between a core-side byte/word source and the txd pad.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_tx_cfg.sv | 134 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and a future receiver).
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Unused upper bits must be zero; they do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input parity_t mode);
    case (mode)
      EVEN:    parity_bit = ^data;
      ODD:     parity_bit = ~^data;
      default: parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 while not cleared and flags the last cycle of each period.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign bit_tick = !clr && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional parity, 1/2 stop bits,
// one-entry holding register so consecutive frames leave with no idle gap.
module uart_tx_cfg #(
  parameter int CLK_RATE  = 10,
  parameter int BAUD_RATE = 1,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 data_write_valid,
  output logic                 data_write_ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 txd_out,
  output logic                 tx_busy
);
  import uart_pkg::*;

  localparam int      DIV      = CLK_RATE / BAUD_RATE;
  localparam int      BCW      = $clog2(DATA_BITS + 1);
  localparam parity_t PAR_MODE = parity_t'(PARITY);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_check
    $fatal(1, "uart_tx_cfg: illegal parameter combination");
  end

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift;
  logic                 hold_full;
  logic                 par_bit;
  logic [BCW-1:0]       bit_cnt;
  logic                 bit_tick;
  logic                 accept;
  logic                 load;
  logic                 txd_next;

  assign data_write_ready = !hold_full;
  assign accept           = data_write_valid && !hold_full;
  assign tx_busy          = (state != IDLE) || hold_full;

  // Counter is held at zero in IDLE so every frame starts on a fresh bit boundary.
  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (areset),
    .clr     (state == IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = START;
          load       = 1'b1;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick && bit_cnt == BCW'(DATA_BITS - 1)) begin
          state_next = (PAR_MODE != NONE) ? uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick && bit_cnt == BCW'(STOP_BITS - 1)) begin
          if (hold_full) begin
            state_next = START;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level follows the state one cycle later, keeping every bit exactly DIV cycles.
  always_comb begin
    txd_next = 1'b1;
    case (state)
      START:            txd_next = 1'b0;
      DATA:             txd_next = shift[0];
      uart_pkg::PARITY: txd_next = par_bit;
      default:          txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      txd_out   <= 1'b1;
    end else begin
      state   <= state_next;
      txd_out <= txd_next;
      if (accept) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (bit_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= data_in;
    end
    if (load) begin
      shift   <= hold_data;
      par_bit <= parity_bit(MAX_DATA_BITS'(hold_data), PAR_MODE);
    end else if (state == DATA && bit_tick) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations (8E1, 7O1, 8N2, 9N1) at 10 clocks per bit.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       areset;
  logic [3:0] valid;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] d3;
  wire  [3:0] txd;
  wire  [3:0] rdy;
  wire  [3:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_RATE(10), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .areset(areset), .data_write_valid(valid[0]), .data_write_ready(rdy[0]),
    .data_in(d0), .txd_out(txd[0]), .tx_busy(busy[0]));

  uart_tx_cfg #(.CLK_RATE(10), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .areset(areset), .data_write_valid(valid[1]), .data_write_ready(rdy[1]),
    .data_in(d1), .txd_out(txd[1]), .tx_busy(busy[1]));

  uart_tx_cfg #(.CLK_RATE(10), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .areset(areset), .data_write_valid(valid[2]), .data_write_ready(rdy[2]),
    .data_in(d2), .txd_out(txd[2]), .tx_busy(busy[2]));

  uart_tx_cfg #(.CLK_RATE(10), .BAUD_RATE(1), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .areset(areset), .data_write_valid(valid[3]), .data_write_ready(rdy[3]),
    .data_in(d3), .txd_out(txd[3]), .tx_busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [8:0] w);
    case (k)
      0:       d0 = w[7:0];
      1:       d1 = w[6:0];
      2:       d2 = w[7:0];
      default: d3 = w;
    endcase
  endtask

  // Offers one word for a single cycle; returns just after the accepting edge.
  task automatic send(input int k, input logic [8:0] w);
    valid[k] = 1'b1;
    set_data(k, w);
    tick();
    valid[k] = 1'b0;
    chk("ready_after_accept", 32'(rdy[k]), 32'd0);
    chk("busy_after_accept", 32'(busy[k]), 32'd1);
    chk("txd_after_accept", 32'(txd[k]), 32'd1);
  endtask

  // Entered on the first cycle of the start bit; pat[i] is the i-th bit on the line.
  task automatic check_frame(input int k, input logic [31:0] pat, input int nb, input int rdy_from);
    for (int i = 0; i < nb * 10; i++) begin
      chk("txd_bit", 32'(txd[k]), 32'(pat[i / 10]));
      chk("ready_in_frame", 32'(rdy[k]), 32'(i >= rdy_from));
      chk("busy_in_frame", 32'(busy[k]), 32'(i < nb * 10 - 1));
      tick();
    end
    chk("txd_idle_after", 32'(txd[k]), 32'd1);
    chk("busy_idle_after", 32'(busy[k]), 32'd0);
    chk("ready_idle_after", 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    areset = 1'b1;
    valid  = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    tick();
    tick();
    areset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("reset_txd", 32'(txd[k]), 32'd1);
      chk("reset_ready", 32'(rdy[k]), 32'd1);
      chk("reset_busy", 32'(busy[k]), 32'd0);
    end

    // 8E1, 0xA5: 0 | 1 0 1 0 0 1 0 1 | parity 0 | 1
    send(0, 9'h0A5);
    tick();
    chk("8e1_txd_lat1", 32'(txd[0]), 32'd1);
    chk("8e1_ready_lat1", 32'(rdy[0]), 32'd1);
    tick();
    check_frame(0, 32'b10101001010, 11, 0);

    // 7O1, 0x07 with an extra word offered while ready is low (must be ignored)
    send(1, 9'h007);
    valid[1] = 1'b1;
    set_data(1, 9'h055);
    tick();
    valid[1] = 1'b0;
    chk("7o1_ready_lat1", 32'(rdy[1]), 32'd1);
    tick();
    check_frame(1, 32'b1000001110, 10, 0);
    for (int i = 0; i < 30; i++) begin
      chk("7o1_stays_idle", 32'(txd[1]), 32'd1);
      chk("7o1_busy_idle", 32'(busy[1]), 32'd0);
      tick();
    end

    // 8N2, 0x00 then 0xFF with valid held: two frames with no idle cycle between
    send(2, 9'h000);
    valid[2] = 1'b1;
    set_data(2, 9'h0FF);
    tick();
    chk("8n2_ready_lat1", 32'(rdy[2]), 32'd1);
    tick();
    valid[2] = 1'b0;
    check_frame(2, {10'b0, 11'b11111111110, 11'b11000000000}, 22, 109);

    // 9N1, 0x1FF: start, nine ones, stop
    send(3, 9'h1FF);
    tick();
    tick();
    check_frame(3, 32'b11111111110, 11, 0);

    // Reset during data bit 3 of 8E1 with a second word pending
    send(0, 9'h03C);
    valid[0] = 1'b1;
    set_data(0, 9'h081);
    tick();
    tick();
    valid[0] = 1'b0;
    chk("rst_pending_full", 32'(rdy[0]), 32'd0);
    for (int i = 0; i < 44; i++) tick();
    chk("rst_mid_bit3", 32'(txd[0]), 32'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rst_txd", 32'(txd[0]), 32'd1);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 150; i++) begin
      chk("rst_no_resend", 32'(txd[0]), 32'd1);
      tick();
    end
    chk("rst_busy_end", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
